// File: rtl/prienc_n_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prienc_pkg
//  Description : Shared types and constants for the N-input priority
//                encoder / arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package prienc_pkg;

   // Arbiter FSM states
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Encoding mode selected by the mode input
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage : prienc_pkg
`default_nettype wire

// File: rtl/prienc_n_arb_core.sv
`default_nettype none
// ============================================================================
//  Module      : prienc_core
//  Description : Combinational N-bit fixed-priority encoder. The highest set
//                bit wins; found_o flags a non-zero input.
//  Revision    : 1.0 - initial release
// ============================================================================
module prienc_core #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] vec_i,
   output logic [W-1:0] idx_o,
   output logic         found_o
);

   // Ascending scan: later (higher) set bits overwrite earlier ones
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec_i[i]) begin
            idx_o   = W'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule : prienc_core
`default_nettype wire

// File: rtl/prienc_n_arb.sv
`default_nettype none
// ============================================================================
//  Module      : prienc_n_arb
//  Description : Registered N-input priority encoder / arbiter. Samples req
//                on en, encodes it in fixed (highest index wins) or
//                round-robin mode, and holds the grant until ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module prienc_n_arb
   import prienc_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_i,
   input  logic         mode_i,
   input  logic         en_i,
   input  logic         ack_i,
   output logic [W-1:0] idx_o,
   output logic         valid_o,
   output logic [N-1:0] gnt_o
);

   state_t         state_q, state_d;
   logic [W-1:0]   idx_q,   idx_d;
   logic [W-1:0]   ptr_q,   ptr_d;
   logic           rr_q,    rr_d;     // current grant was issued in round-robin mode

   logic [N-1:0]   w_rot;
   logic [N-1:0]   w_enc_in;
   logic [W-1:0]   w_enc_idx;
   logic           w_found;
   logic [W-1:0]   w_grant_idx;

   // Rotate req so that req[ptr] lands in the MSB; the W-bit index sum wraps mod N
   always_comb begin
      w_rot = '0;
      for (int j = 0; j < N; j++) begin
         w_rot[j] = req_i[W'(j) + ptr_q + W'(1)];
      end
   end

   assign w_enc_in = (mode_i == MODE_RR) ? w_rot : req_i;

   prienc_core #(
      .N (N)
   ) u_core (
      .vec_i   (w_enc_in),
      .idx_o   (w_enc_idx),
      .found_o (w_found)
   );

   // Undo the rotation offset in round-robin mode
   assign w_grant_idx = (mode_i == MODE_RR) ? (w_enc_idx + ptr_q + W'(1)) : w_enc_idx;

   // Next-state logic: sample in IDLE, hold in GRANT until ack
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      rr_d    = rr_q;
      unique case (state_q)
         IDLE: begin
            if (en_i && w_found) begin
               idx_d   = w_grant_idx;
               rr_d    = mode_i;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (ack_i) begin
               state_d = IDLE;
               if (rr_q == MODE_RR) begin
                  ptr_d = idx_q - W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         ptr_q   <= '1;
         rr_q    <= MODE_FIXED;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         rr_q    <= rr_d;
      end
   end

   assign idx_o   = idx_q;
   assign valid_o = (state_q == GRANT);

   // One-hot grant decoded from registered index and state only
   always_comb begin
      gnt_o = '0;
      if (state_q == GRANT) begin
         gnt_o[idx_q] = 1'b1;
      end
   end

endmodule : prienc_n_arb
`default_nettype wire
